// File: rtl/groovy_cmd_seq.sv
// Command sequencer between the HPS extension bus block and the video pipeline.
// Serialises init / switchres / blit requests and runs their start/done handshakes.
module groovy_cmd_seq #(
  parameter int unsigned      TMO_W     = 24,
  parameter logic [TMO_W-1:0] TMO_CYC   = TMO_W'(5000000),
  parameter bit               VBL_ALIGN = 1'b1
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic cmd_init,
  input  logic cmd_switchres,
  input  logic cmd_blit,
  input  logic cmd_logo,
  input  logic vga_vblank,
  input  logic mode_ack,
  input  logic blit_done,
  output logic core_init,
  output logic mode_load,
  output logic blit_start,
  output logic reset_switchres,
  output logic reset_blit,
  output logic logo_en,
  output logic busy,
  output logic tmo_err
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StWaitVbl,
    StLoad,
    StWaitMode,
    StBlit,
    StWaitBlit
  } state_e;

  localparam logic [TMO_W-1:0] TmoLast = TMO_CYC - TMO_W'(1);

  state_e           state;
  logic             cmd_init_d;
  logic             vblank_d;
  logic             init_pend;
  logic             logo_q;
  logic [TMO_W-1:0] tmo_cnt;

  logic init_rise;
  logic vbl_rise;
  logic clear_cycle;

  assign init_rise   = cmd_init & ~cmd_init_d;
  assign vbl_rise    = vga_vblank & ~vblank_d;
  // cmd_switchres/cmd_blit are still high while their clear pulse is out
  assign clear_cycle = reset_switchres | reset_blit;

  assign logo_en = logo_q & ~(state inside {StInit, StWaitVbl, StLoad, StWaitMode});

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state           <= StIdle;
      cmd_init_d      <= 1'b0;
      vblank_d        <= 1'b0;
      init_pend       <= 1'b0;
      logo_q          <= 1'b0;
      tmo_cnt         <= '0;
      core_init       <= 1'b0;
      mode_load       <= 1'b0;
      blit_start      <= 1'b0;
      reset_switchres <= 1'b0;
      reset_blit      <= 1'b0;
      busy            <= 1'b0;
      tmo_err         <= 1'b0;
    end else begin
      cmd_init_d      <= cmd_init;
      vblank_d        <= vga_vblank;
      logo_q          <= cmd_logo;
      core_init       <= 1'b0;
      mode_load       <= 1'b0;
      blit_start      <= 1'b0;
      reset_switchres <= 1'b0;
      reset_blit      <= 1'b0;
      if (init_rise) init_pend <= 1'b1;

      case (state)
        StIdle: begin
          // A same-cycle init edge still beats switchres/blit
          if (init_pend || init_rise) begin
            state     <= StInit;
            core_init <= 1'b1;
            busy      <= 1'b1;
          end else if (!clear_cycle && cmd_switchres) begin
            busy <= 1'b1;
            if (VBL_ALIGN) begin
              state <= StWaitVbl;
            end else begin
              state     <= StLoad;
              mode_load <= 1'b1;
            end
          end else if (!clear_cycle && cmd_blit) begin
            state      <= StBlit;
            blit_start <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StInit: begin
          init_pend <= init_rise;
          tmo_err   <= 1'b0;
          state     <= StIdle;
          busy      <= 1'b0;
        end
        StWaitVbl: begin
          if (vbl_rise) begin
            state     <= StLoad;
            mode_load <= 1'b1;
          end
        end
        StLoad: begin
          tmo_cnt <= '0;
          state   <= StWaitMode;
        end
        StWaitMode: begin
          if (mode_ack || tmo_cnt == TmoLast) begin
            if (!mode_ack) tmo_err <= 1'b1;
            reset_switchres <= 1'b1;
            state           <= StIdle;
            busy            <= 1'b0;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        StBlit: begin
          tmo_cnt <= '0;
          state   <= StWaitBlit;
        end
        StWaitBlit: begin
          if (blit_done || tmo_cnt == TmoLast) begin
            if (!blit_done) tmo_err <= 1'b1;
            reset_blit <= 1'b1;
            state      <= StIdle;
            busy       <= 1'b0;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_groovy_cmd_seq.sv
// Directed bench for groovy_cmd_seq; outputs are packed as
// {core_init, mode_load, blit_start, reset_switchres, reset_blit, logo_en, busy, tmo_err}.
module tb_groovy_cmd_seq;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic cmd_init, cmd_switchres, cmd_blit, cmd_logo, vga_vblank, mode_ack, blit_done;
  logic core_init, mode_load, blit_start, reset_switchres, reset_blit, logo_en, busy, tmo_err;
  logic [7:0] outs;
  int n_tests = 0;
  int n_fail  = 0;

  assign outs = {core_init, mode_load, blit_start, reset_switchres, reset_blit, logo_en, busy,
                 tmo_err};

  groovy_cmd_seq #(
    .TMO_W    (24),
    .TMO_CYC  (24'd16),
    .VBL_ALIGN(1'b1)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .cmd_init       (cmd_init),
    .cmd_switchres  (cmd_switchres),
    .cmd_blit       (cmd_blit),
    .cmd_logo       (cmd_logo),
    .vga_vblank     (vga_vblank),
    .mode_ack       (mode_ack),
    .blit_done      (blit_done),
    .core_init      (core_init),
    .mode_load      (mode_load),
    .blit_start     (blit_start),
    .reset_switchres(reset_switchres),
    .reset_blit     (reset_blit),
    .logo_en        (logo_en),
    .busy           (busy),
    .tmo_err        (tmo_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_init = 0; cmd_switchres = 0; cmd_blit = 0; cmd_logo = 0;
    vga_vblank = 0; mode_ack = 0; blit_done = 0;
    #1;
    n_tests++; if (outs !== 8'b0000_0000) begin n_fail++;
      $display("FAIL reset_in: got %b want 00000000", outs); end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    n_tests++; if (outs !== 8'b0000_0000) begin n_fail++;
      $display("FAIL reset_idle: got %b want 00000000", outs); end
  endtask

  task automatic test_blit();
    int starts;
    cmd_blit = 1;
    tick();  // t+1
    starts = int'(blit_start);
    n_tests++; if (outs !== 8'b0010_0010) begin n_fail++;
      $display("FAIL blit_start_t1: got %b want 00100010", outs); end
    for (int i = 2; i <= 10; i++) begin
      tick();
      starts += int'(blit_start);
    end
    n_tests++; if (outs !== 8'b0000_0010) begin n_fail++;
      $display("FAIL blit_wait_t10: got %b want 00000010", outs); end
    blit_done = 1;
    tick();  // t+11
    blit_done = 0;
    n_tests++; if (outs !== 8'b0000_1000) begin n_fail++;
      $display("FAIL blit_clear_t11: got %b want 00001000", outs); end
    tick();  // clear cycle must not re-grant the still-high cmd_blit
    starts += int'(blit_start);
    cmd_blit = 0;
    n_tests++; if (outs !== 8'b0000_0000) begin n_fail++;
      $display("FAIL blit_no_regrant: got %b want 00000000", outs); end
    n_tests++; if (starts !== 1) begin n_fail++;
      $display("FAIL blit_start_count: got %0d want 1", starts); end
  endtask

  task automatic test_switchres();
    int loads;
    vga_vblank = 1;
    tick();
    cmd_switchres = 1;
    tick();
    loads = int'(mode_load);
    n_tests++; if (outs !== 8'b0000_0010) begin n_fail++;
      $display("FAIL sw_wait_vbl: got %b want 00000010", outs); end
    for (int i = 0; i < 5; i++) begin tick(); loads += int'(mode_load); end
    vga_vblank = 0;
    for (int i = 0; i < 3; i++) begin tick(); loads += int'(mode_load); end
    n_tests++; if (loads !== 0) begin n_fail++;
      $display("FAIL sw_early_load: got %0d loads want 0", loads); end
    vga_vblank = 1;
    tick();
    n_tests++; if (outs !== 8'b0100_0010) begin n_fail++;
      $display("FAIL sw_mode_load: got %b want 01000010", outs); end
    tick(); tick();
    n_tests++; if (outs !== 8'b0000_0010) begin n_fail++;
      $display("FAIL sw_wait_mode: got %b want 00000010", outs); end
    mode_ack = 1;
    tick();
    mode_ack = 0;
    n_tests++; if (outs !== 8'b0001_0000) begin n_fail++;
      $display("FAIL sw_clear: got %b want 00010000", outs); end
    tick();
    cmd_switchres = 0;
    vga_vblank = 0;
    n_tests++; if (outs !== 8'b0000_0000) begin n_fail++;
      $display("FAIL sw_no_regrant: got %b want 00000000", outs); end
  endtask

  task automatic test_priority();
    cmd_init = 1; cmd_switchres = 1; cmd_blit = 1;
    tick();
    n_tests++; if (outs !== 8'b1000_0010) begin n_fail++;
      $display("FAIL prio_init_first: got %b want 10000010", outs); end
    tick();
    n_tests++; if (outs !== 8'b0000_0000) begin n_fail++;
      $display("FAIL prio_after_init: got %b want 00000000", outs); end
    tick();
    n_tests++; if (outs !== 8'b0000_0010) begin n_fail++;
      $display("FAIL prio_sw_second: got %b want 00000010", outs); end
    vga_vblank = 1;
    tick();
    vga_vblank = 0;
    n_tests++; if (outs !== 8'b0100_0010) begin n_fail++;
      $display("FAIL prio_mode_load: got %b want 01000010", outs); end
    tick();
    mode_ack = 1;
    tick();
    mode_ack = 0;
    n_tests++; if (outs !== 8'b0001_0000) begin n_fail++;
      $display("FAIL prio_sw_clear: got %b want 00010000", outs); end
    cmd_switchres = 0;
    tick();
    n_tests++; if (outs !== 8'b0000_0000) begin n_fail++;
      $display("FAIL prio_clear_gap: got %b want 00000000", outs); end
    tick();
    n_tests++; if (outs !== 8'b0010_0010) begin n_fail++;
      $display("FAIL prio_blit_last: got %b want 00100010", outs); end
    tick();
    blit_done = 1;
    tick();
    blit_done = 0;
    cmd_blit = 0; cmd_init = 0;
    n_tests++; if (outs !== 8'b0000_1000) begin n_fail++;
      $display("FAIL prio_blit_clear: got %b want 00001000", outs); end
    tick();
  endtask

  task automatic test_timeout();
    int early;
    cmd_blit = 1;
    tick();  // blit_start cycle
    early = 0;
    for (int i = 0; i < 16; i++) begin tick(); early += int'(reset_blit); end
    n_tests++; if (outs !== 8'b0000_0010 || early !== 0) begin n_fail++;
      $display("FAIL tmo_not_yet: got %b/%0d want 00000010/0", outs, early); end
    tick();  // 16 WAIT_BLIT cycles elapsed
    n_tests++; if (outs !== 8'b0000_1001) begin n_fail++;
      $display("FAIL tmo_abort: got %b want 00001001", outs); end
    tick();
    cmd_blit = 0;
    n_tests++; if (outs !== 8'b0000_0001) begin n_fail++;
      $display("FAIL tmo_sticky: got %b want 00000001", outs); end
    cmd_init = 1;
    tick();
    n_tests++; if (outs !== 8'b1000_0011) begin n_fail++;
      $display("FAIL tmo_core_init: got %b want 10000011", outs); end
    tick();
    cmd_init = 0;
    n_tests++; if (outs !== 8'b0000_0000) begin n_fail++;
      $display("FAIL tmo_cleared: got %b want 00000000", outs); end
  endtask

  task automatic test_logo();
    cmd_logo = 1;
    tick();
    n_tests++; if (outs !== 8'b0000_0100) begin n_fail++;
      $display("FAIL logo_on: got %b want 00000100", outs); end
    cmd_switchres = 1;
    tick();
    n_tests++; if (outs !== 8'b0000_0010) begin n_fail++;
      $display("FAIL logo_wait_vbl: got %b want 00000010", outs); end
    vga_vblank = 1;
    tick();
    vga_vblank = 0;
    n_tests++; if (outs !== 8'b0100_0010) begin n_fail++;
      $display("FAIL logo_load: got %b want 01000010", outs); end
    tick();
    mode_ack = 1;
    tick();
    mode_ack = 0;
    cmd_switchres = 0;
    n_tests++; if (outs !== 8'b0001_0100) begin n_fail++;
      $display("FAIL logo_restore: got %b want 00010100", outs); end
    tick();
    cmd_blit = 1;
    tick();
    n_tests++; if (outs !== 8'b0010_0110) begin n_fail++;
      $display("FAIL logo_blit: got %b want 00100110", outs); end
    tick();
    cmd_init = 1;
    tick(); tick();
    n_tests++; if (outs !== 8'b0000_0110) begin n_fail++;
      $display("FAIL logo_init_held: got %b want 00000110", outs); end
    blit_done = 1;
    tick();
    blit_done = 0;
    n_tests++; if (outs !== 8'b0000_1100) begin n_fail++;
      $display("FAIL logo_blit_clear: got %b want 00001100", outs); end
    tick();
    cmd_blit = 0;
    n_tests++; if (outs !== 8'b1000_0010) begin n_fail++;
      $display("FAIL logo_late_init: got %b want 10000010", outs); end
    tick();
    cmd_init = 0; cmd_logo = 0;
    n_tests++; if (outs !== 8'b0000_0100) begin n_fail++;
      $display("FAIL logo_after_init: got %b want 00000100", outs); end
    tick();
  endtask

  task automatic test_reset_mid();
    cmd_blit = 1;
    tick(); tick(); tick();
    n_tests++; if (outs !== 8'b0000_0010) begin n_fail++;
      $display("FAIL rst_pre_wait: got %b want 00000010", outs); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (outs !== 8'b0000_0000) begin n_fail++;
      $display("FAIL rst_async: got %b want 00000000", outs); end
    tick();
    reset_n = 1'b1;
    tick();
    n_tests++; if (outs !== 8'b0010_0010) begin n_fail++;
      $display("FAIL rst_blit_restart: got %b want 00100010", outs); end
    tick();
    blit_done = 1;
    tick();
    blit_done = 0;
    cmd_blit = 0;
    n_tests++; if (outs !== 8'b0000_1000) begin n_fail++;
      $display("FAIL rst_blit_clear: got %b want 00001000", outs); end
    tick();
  endtask

  initial begin
    test_reset();
    test_blit();
    test_switchres();
    test_priority();
    test_timeout();
    test_logo();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
